// File: rtl/tilexy_pkg.sv
// Shared definitions for the tile X/Y mesh output-link arbiter: wrreq beat layout,
// credit-width helper and the controller state encoding.
package tilexy_pkg;

    // wrreq beat layout, LSB first: TX, TY, sz, addr, byte enables, data
    localparam int WR_TX_LSB   = 0;
    localparam int WR_TX_W     = 4;
    localparam int WR_TY_LSB   = WR_TX_LSB + WR_TX_W;
    localparam int WR_TY_W     = 4;
    localparam int WR_SZ_LSB   = WR_TY_LSB + WR_TY_W;
    localparam int WR_SZ_W     = 7;
    localparam int WR_ADDR_LSB = WR_SZ_LSB + WR_SZ_W;
    localparam int WR_ADDR_W   = 64;
    localparam int WR_BE_LSB   = WR_ADDR_LSB + WR_ADDR_W;
    localparam int WR_BE_W     = 64;
    localparam int WR_DATA_LSB = WR_BE_LSB + WR_BE_W;
    localparam int WR_DATA_W   = 512;
    localparam int WRREQ_W     = WR_DATA_LSB + WR_DATA_W;

    localparam int CREDITS_DEF = 8;

    // Width needed to hold a credit count from 0 up to and including credits.
    function automatic int calc_cw(input int credits);
        return $clog2(credits + 1);
    endfunction

    localparam int CW = calc_cw(CREDITS_DEF);

    typedef enum logic {
        RUN   = 1'b0,
        BLOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tilexy_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping N-1 -> 0.
// Produces a one-hot grant, its index and an any-request flag.
module tilexy_rr_pick
    import tilexy_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/tilexy_link_arb.sv
// Output-link arbiter and credit controller for one mesh direction.
// Optional starvation override is enabled by defining TILE_ARB_STARVE_EN.
module tilexy_link_arb
    import tilexy_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int DW         = WRREQ_W,
    parameter int CREDITS    = CREDITS_DEF,
    parameter int STARVE_LIM = 15,
    parameter int CW         = calc_cw(CREDITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_pri,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               link_hold,
    input  logic               crd_ret,
    output logic [NREQ-1:0]    gnt,
    output logic               out_snd,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      credits,
    output logic               err_ovf,
    output arb_state_e         dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [CW-1:0]   credits_q, credits_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            out_snd_q, out_snd_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            err_ovf_q, err_ovf_d;
    arb_state_e      state_q, state_d;

    logic            can_send;
    logic [NREQ-1:0] elig, pri_elig;
    logic [NREQ-1:0] pri_oh, all_oh;
    logic [PW-1:0]   pri_idx, all_idx;
    logic            pri_any, all_any;
    logic [PW-1:0]   stv_idx;
    logic            stv_any;
    logic [PW-1:0]   sel_idx;
    logic            sel_any;
    logic [NREQ-1:0] gnt_w;
    logic            granted;
    logic [DW-1:0]   sel_beat;

    assign can_send = (credits_q != '0) && !link_hold;
    assign elig     = req & {NREQ{can_send}};
    assign pri_elig = elig & req_pri;

    tilexy_rr_pick #(.N(NREQ), .PW(PW)) u_pick_pri (
        .req_i (pri_elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (pri_oh),
        .idx_o (pri_idx),
        .any_o (pri_any)
    );

    tilexy_rr_pick #(.N(NREQ), .PW(PW)) u_pick_all (
        .req_i (elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (all_oh),
        .idx_o (all_idx),
        .any_o (all_any)
    );

`ifdef TILE_ARB_STARVE_EN
    localparam logic [3:0] STARVE_SAT = 4'(STARVE_LIM);

    logic [3:0] wait_q [NREQ];
    logic [3:0] wait_d [NREQ];

    // Lowest starved index wins, so scan downwards and let later hits overwrite.
    always_comb begin
        stv_idx = '0;
        stv_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i] && (wait_q[i] == STARVE_SAT)) begin
                stv_idx = PW'(i);
                stv_any = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wait_d[i] = wait_q[i];
            if (!req[i] || gnt_w[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != STARVE_SAT) begin
                wait_d[i] = wait_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
`else
    assign stv_idx = '0;
    assign stv_any = 1'b0;
`endif

    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        if (stv_any) begin
            sel_idx = stv_idx;
            sel_any = 1'b1;
        end else if (pri_any) begin
            sel_idx = pri_idx;
            sel_any = 1'b1;
        end else if (all_any) begin
            sel_idx = all_idx;
            sel_any = 1'b1;
        end
    end

    // Grant is held off for the whole reset pulse, not just until the first edge.
    always_comb begin
        gnt_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_w[i] = sel_any && !rst && (int'(sel_idx) == i);
        end
    end

    assign granted  = |gnt_w;
    assign sel_beat = req_data[int'(sel_idx)*DW +: DW];

    always_comb begin
        credits_d  = credits_q;
        err_ovf_d  = err_ovf_q;
        rr_ptr_d   = rr_ptr_q;
        out_snd_d  = granted;
        out_data_d = out_data_q;
        if (granted && !crd_ret) begin
            credits_d = credits_q - CW'(1);
        end else if (!granted && crd_ret) begin
            if (credits_q == CW'(CREDITS)) begin
                err_ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end
        if (granted) begin
            rr_ptr_d   = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
            out_data_d = sel_beat;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (link_hold || (granted && !crd_ret && credits_q == CW'(1))) begin
                    state_d = BLOCK;
                end
            end
            BLOCK: begin
                if (can_send) begin
                    state_d = RUN;
                end
            end
            default: state_d = BLOCK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q  <= CW'(CREDITS);
            rr_ptr_q   <= '0;
            out_snd_q  <= 1'b0;
            out_data_q <= '0;
            err_ovf_q  <= 1'b0;
            state_q    <= RUN;
        end else begin
            credits_q  <= credits_d;
            rr_ptr_q   <= rr_ptr_d;
            out_snd_q  <= out_snd_d;
            out_data_q <= out_data_d;
            err_ovf_q  <= err_ovf_d;
            state_q    <= state_d;
        end
    end

    assign gnt       = gnt_w;
    assign out_snd   = out_snd_q;
    assign out_data  = out_data_q;
    assign credits   = credits_q;
    assign err_ovf   = err_ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tilexy_link_arb.sv
// Self-checking bench for tilexy_link_arb: scenario tasks plus a beat scoreboard.
// Define TILE_ARB_STARVE_EN for both bench and RTL to exercise the starvation override.
module tb_tilexy_link_arb;
    import tilexy_pkg::*;

    localparam int NREQ    = 3;
    localparam int DW      = 655;
    localparam int CREDITS = 8;
    localparam int CW      = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_pri;
    logic [NREQ*DW-1:0] req_data;
    logic               link_hold;
    logic               crd_ret;
    logic [NREQ-1:0]    gnt;
    logic               out_snd;
    logic [DW-1:0]      out_data;
    logic [CW-1:0]      credits;
    logic               err_ovf;
    arb_state_e         dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    tilexy_link_arb #(
        .NREQ       (NREQ),
        .DW         (DW),
        .CREDITS    (CREDITS),
        .STARVE_LIM (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_pri   (req_pri),
        .req_data  (req_data),
        .link_hold (link_hold),
        .crd_ret   (crd_ret),
        .gnt       (gnt),
        .out_snd   (out_snd),
        .out_data  (out_data),
        .credits   (credits),
        .err_ovf   (err_ovf),
        .dbg_state (dbg_state)
    );

    // Scoreboard: every link beat must match the oldest expected beat.
    always @(negedge clk) begin
        logic [DW-1:0] exp_beat;
        if (rst === 1'b0 && out_snd === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: out_snd=1 low64=%h with no beat expected", out_data[63:0]);
            end else begin
                exp_beat = exp_q.pop_front();
                if (out_data !== exp_beat) begin
                    errors++;
                    $display("FAIL beat_data: low64=%h required %h", out_data[63:0], exp_beat[63:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int k);
        for (int b = 0; b < DW; b++) begin
            req_data[k*DW + b] = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic logic [DW-1:0] beat_of(input int k);
        return req_data[k*DW +: DW];
    endfunction

    task automatic do_reset();
        req       = '0;
        req_pri   = '0;
        crd_ret   = 1'b0;
        link_hold = 1'b0;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int seq [4] = '{0, 1, 2, 0};
        rst       = 1'b1;
        req       = 3'b111;
        req_pri   = '0;
        crd_ret   = 1'b0;
        link_hold = 1'b0;
        for (int k = 0; k < NREQ; k++) set_beat(k);
        tick();
        tick();
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: gnt=%b required 000", gnt); end
        checks++; if (credits !== 4'd8) begin errors++; $display("FAIL reset_credits: credits=%0d required 8", credits); end
        checks++; if (out_snd !== 1'b0) begin errors++; $display("FAIL reset_snd: out_snd=%b required 0", out_snd); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: low64=%h required 0", out_data[63:0]); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: err_ovf=%b required 0", err_ovf); end
        checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state: state=%0d required RUN", dbg_state); end
        tick();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if (gnt !== NREQ'(1 << seq[n])) begin
                errors++;
                $display("FAIL rr_order[%0d]: gnt=%b required %b", n, gnt, NREQ'(1 << seq[n]));
            end
            exp_q.push_back(beat_of(seq[n]));
            tick();
            set_beat(seq[n]);
        end
        req = '0;
        @(negedge clk);
        checks++; if (credits !== 4'd4) begin errors++; $display("FAIL rr_credits: credits=%0d required 4", credits); end
    endtask

    task automatic test_pri_credits();
        do_reset();
        req     = 3'b111;
        req_pri = 3'b010;
        for (int n = 0; n < CREDITS; n++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 3'b010) begin errors++; $display("FAIL pri_grant[%0d]: gnt=%b required 010", n, gnt); end
            exp_q.push_back(beat_of(1));
            tick();
            set_beat(1);
        end
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL empty_gnt: gnt=%b required 000", gnt); end
        checks++; if (credits !== 4'd0) begin errors++; $display("FAIL empty_credits: credits=%0d required 0", credits); end
        checks++; if (dbg_state !== BLOCK) begin errors++; $display("FAIL empty_state: state=%0d required BLOCK", dbg_state); end
        tick();
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL empty_gnt2: gnt=%b required 000", gnt); end
        tick();
        crd_ret = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL no_bypass: gnt=%b required 000", gnt); end
        tick();
        crd_ret = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL ret_grant: gnt=%b required 010", gnt); end
        checks++; if (credits !== 4'd1) begin errors++; $display("FAIL ret_credits: credits=%0d required 1", credits); end
        exp_q.push_back(beat_of(1));
        tick();
        set_beat(1);
        @(negedge clk);
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL ret_once: gnt=%b required 000", gnt); end
        checks++; if (credits !== 4'd0) begin errors++; $display("FAIL ret_credits0: credits=%0d required 0", credits); end
        req = '0;
    endtask

    task automatic test_pri_rr();
        int seq [6] = '{0, 2, 0, 2, 0, 1};
        do_reset();
        req     = 3'b111;
        req_pri = 3'b101;
        for (int n = 0; n < 6; n++) begin
            if (n == 4) req_pri = 3'b000;
            @(negedge clk);
            checks++;
            if (gnt !== NREQ'(1 << seq[n])) begin
                errors++;
                $display("FAIL pri_rr[%0d]: gnt=%b required %b", n, gnt, NREQ'(1 << seq[n]));
            end
            exp_q.push_back(beat_of(seq[n]));
            tick();
            set_beat(seq[n]);
        end
        req = '0;
    endtask

    task automatic test_latency();
        logic [DW-1:0] b;
        do_reset();
        set_beat(2);
        req = 3'b100;
        @(negedge clk);
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL lat_gnt: gnt=%b required 100", gnt); end
        b = beat_of(2);
        exp_q.push_back(b);
        tick();
        req = '0;
        set_beat(2);
        @(negedge clk);
        checks++; if (out_snd !== 1'b1) begin errors++; $display("FAIL lat_snd: out_snd=%b required 1", out_snd); end
        checks++; if (out_data !== b) begin errors++; $display("FAIL lat_data: low64=%h required %h", out_data[63:0], b[63:0]); end
        tick();
        @(negedge clk);
        checks++; if (out_snd !== 1'b0) begin errors++; $display("FAIL idle_snd: out_snd=%b required 0", out_snd); end
        checks++; if (out_data !== b) begin errors++; $display("FAIL idle_hold: low64=%h required %h", out_data[63:0], b[63:0]); end
    endtask

    task automatic test_credit_edges();
        do_reset();
        req = 3'b001;
        for (int n = 0; n < 4; n++) begin
            crd_ret = (n == 3);
            @(negedge clk);
            checks++;
            if (gnt !== 3'b001) begin errors++; $display("FAIL edge_gnt[%0d]: gnt=%b required 001", n, gnt); end
            exp_q.push_back(beat_of(0));
            tick();
            set_beat(0);
        end
        req     = '0;
        crd_ret = 1'b0;
        @(negedge clk);
        checks++; if (credits !== 4'd5) begin errors++; $display("FAIL gnt_and_ret: credits=%0d required 5", credits); end
        crd_ret = 1'b1;
        tick();
        tick();
        tick();
        crd_ret = 1'b0;
        @(negedge clk);
        checks++; if (credits !== 4'd8) begin errors++; $display("FAIL refill: credits=%0d required 8", credits); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL refill_ovf: err_ovf=%b required 0", err_ovf); end
        crd_ret = 1'b1;
        tick();
        crd_ret = 1'b0;
        @(negedge clk);
        checks++; if (credits !== 4'd8) begin errors++; $display("FAIL ovf_sat: credits=%0d required 8", credits); end
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: err_ovf=%b required 1", err_ovf); end
        tick();
        tick();
        tick();
        req = 3'b001;
        @(negedge clk);
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL ovf_gnt: gnt=%b required 001", gnt); end
        exp_q.push_back(beat_of(0));
        tick();
        set_beat(0);
        req = '0;
        @(negedge clk);
        checks++; if (credits !== 4'd7) begin errors++; $display("FAIL ovf_credits: credits=%0d required 7", credits); end
        checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: err_ovf=%b required 1", err_ovf); end
        do_reset();
        @(negedge clk);
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: err_ovf=%b required 0", err_ovf); end
    endtask

    task automatic test_link_hold();
        do_reset();
        req       = 3'b010;
        link_hold = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 3'b000) begin errors++; $display("FAIL hold_gnt[%0d]: gnt=%b required 000", n, gnt); end
            tick();
        end
        link_hold = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== BLOCK) begin errors++; $display("FAIL hold_state: state=%0d required BLOCK", dbg_state); end
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL hold_release: gnt=%b required 010", gnt); end
        exp_q.push_back(beat_of(1));
        tick();
        set_beat(1);
        req = '0;
        @(negedge clk);
        checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL hold_run: state=%0d required RUN", dbg_state); end
        checks++; if (credits !== 4'd7) begin errors++; $display("FAIL hold_credits: credits=%0d required 7", credits); end
    endtask

    task automatic test_starve();
        int exp_k;
        int first_g0;
        do_reset();
        req      = 3'b111;
        req_pri  = 3'b010;
        crd_ret  = 1'b1;
        first_g0 = -1;
        for (int c = 0; c < 20; c++) begin
`ifdef TILE_ARB_STARVE_EN
            exp_k = (c == 15) ? 0 : (c == 16) ? 2 : 1;
`else
            exp_k = 1;
`endif
            @(negedge clk);
            checks++;
            if (gnt !== NREQ'(1 << exp_k)) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: gnt=%b required %b", c, gnt, NREQ'(1 << exp_k));
            end
            if (gnt[0] === 1'b1 && first_g0 < 0) first_g0 = c;
            exp_q.push_back(beat_of(exp_k));
            tick();
            set_beat(exp_k);
        end
        req     = '0;
        crd_ret = 1'b0;
`ifdef TILE_ARB_STARVE_EN
        checks++; if (first_g0 != 15) begin errors++; $display("FAIL starve_first: first req0 grant cycle=%0d required 15", first_g0); end
`else
        checks++; if (first_g0 != -1) begin errors++; $display("FAIL starve_none: first req0 grant cycle=%0d required never", first_g0); end
`endif
        @(negedge clk);
        checks++; if (credits !== 4'd8) begin errors++; $display("FAIL starve_credits: credits=%0d required 8", credits); end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL starve_ovf: err_ovf=%b required 0", err_ovf); end
    endtask

    initial begin
        test_reset();
        test_pri_credits();
        test_pri_rr();
        test_latency();
        test_credit_edges();
        test_link_hold();
        test_starve();
        req = '0;
        tick();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d beats outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
